cdf_engine: RTL
===============

// Module: cdf_engine
// PURPOSE
//  Parametrised successor CDF engine for histogram equalisation. On start, streams NUM_BINS histogram
//  bins from scratch memory at hist_base, one packed word per cycle. Writes prefix sums (CDF) to
//  cdf_base. Then writes one summary word {cdf_min, cdf_total, 0...} and pulses done.
//  Sits between the histogram block and the equalisation/LUT block on the shared scratch-memory bus.
// PARAMETERS
//  DATA_W   32   width of one bin / CDF value
//  LANES    4    bins per memory word; BUS_W = DATA_W*LANES
//  NUM_BINS 256  bins per run; must be a multiple of LANES, LANES>=2; WORDS = NUM_BINS/LANES
//  ADDR_W   16   scratch-memory address width
//  RD_LAT   1    cycles from ReadAddress valid to ReadBus valid (>=1)
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high reset
//  start        in   1       begin a run; sampled only in IDLE
//  hist_base    in   ADDR_W  first histogram word address; sampled with start
//  cdf_base     in   ADDR_W  first CDF word address; sampled with start
//  ReadAddress  out  ADDR_W  scratch read address (registered)
//  ReadBus      in   BUS_W   scratch read data, lane 0 in MSBs
//  WE           out  1       scratch write enable (registered)
//  WriteAddress out  ADDR_W  scratch write address (registered)
//  WriteBus     out  BUS_W   scratch write data, lane 0 in MSBs (registered)
//  busy         out  1       high from the cycle after start accept through the SUMMARY cycle
//  done         out  1       one-cycle pulse on run completion
//  cdf_min      out  DATA_W  first nonzero CDF value of the last run; 0 if all bins are 0
//  cdf_total    out  DATA_W  final CDF value of the last run (mod 2^DATA_W)
//  overflow     out  1       sticky: a carry out of DATA_W occurred in the last run
// BEHAVIOUR
//  Reset (async): state=IDLE; WE=0, ReadAddress=0, WriteAddress=0, WriteBus=0, busy=0, done=0,
//   cdf_min=0, cdf_total=0, overflow=0; running sum, counters and valid pipe are cleared.
//   Reset mid-run aborts at once; no further writes; a new start is needed.
//  FSM: IDLE -> READ -> DRAIN -> SUMMARY -> DONE -> IDLE.
//   IDLE: WE=0. On start: latch bases, clear running sum/cdf_min/overflow,
//     ReadAddress<=hist_base, go to READ.
//   READ: one read per cycle, WORDS cycles, ReadAddress increments by 1 (wraps mod 2^ADDR_W).
//     After the last address, go to DRAIN.
//   DRAIN: wait until all outstanding reads have returned and been written, then go to SUMMARY.
//   SUMMARY: one cycle with WE=1, WriteAddress=cdf_base+WORDS,
//     WriteBus={cdf_min, cdf_total, zeros in the remaining lanes}.
//   DONE: one cycle with done=1, busy=0, WE=0; start is ignored here. Next state is IDLE.
//  Read return: an RD_LAT-deep valid shift register tracks issued reads. The word is sampled at the
//   end of cycle t+RD_LAT for an address issued in cycle t.
//  Per sampled word: c[i] = run + sum(h[0..i]), each mod 2^DATA_W. Next cycle:
//   WE=1, WriteBus={c[0..LANES-1]}, WriteAddress = cdf_base + word index.
//   run is updated to c[LANES-1] in the same clock edge, so words stream back-to-back.
//   WE drops to 0 in any cycle with no returned word.
//  cdf_min: set to the first nonzero c[i] in lane order; held for the rest of the run.
//  overflow: set if any partial addition carries out of DATA_W.
//  cdf_total/cdf_min/overflow hold their values until the next start is accepted.
//  Latency (start accepted in cycle 0):
//   first data write in cycle 2+RD_LAT;
//   last data write in cycle WORDS+1+RD_LAT;
//   summary write in cycle WORDS+2+RD_LAT;
//   done in cycle WORDS+3+RD_LAT.
//  start outside IDLE is ignored; a held start begins a new run on the cycle after DONE.
// TESTING (NUM_BINS=8, LANES=4, DATA_W=32, RD_LAT=1 unless stated)
//  1 hist {1,2,3,4},{5,6,7,8}, hist_base=0, cdf_base=63 -> writes @63 {1,3,6,10},
//    @64 {15,21,28,36}, @65 {1,36,0,0}; done in cycle 6; overflow=0
//  2 hist {0,0,0,0},{0,5,0,2} -> writes {0,0,0,0},{0,5,5,7}, summary {5,7,0,0}; cdf_min=5
//  3 all-zero histogram -> all CDF words 0, cdf_min=0, cdf_total=0
//  4 DATA_W=8, hist {200,100,0,0},{0,0,0,1} -> {200,44,44,44},{44,44,44,45}; overflow=1, cdf_total=45
//  5 reset asserted in the cycle after the first WE -> WE=0 immediately, no further writes, busy=0;
//    a fresh start reproduces test 1 exactly
//  6 start held high throughout, RD_LAT=3, NUM_BINS=16 -> start pulses in READ/DRAIN ignored;
//    back-to-back runs each give done in cycle 10 after their accept; no write gaps within a run

Source files
------------

// File: rtl/cdf_engine.sv
// CDF engine: streams packed histogram words from scratch memory, writes the running
// prefix sums back word by word, then one {cdf_min, cdf_total} summary word and pulses done.
module cdf_engine #(
    parameter int DATA_W   = 32,
    parameter int LANES    = 4,
    parameter int NUM_BINS = 256,
    parameter int ADDR_W   = 16,
    parameter int RD_LAT   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         hist_base,
    input  logic [ADDR_W-1:0]         cdf_base,
    output logic [ADDR_W-1:0]         ReadAddress,
    input  logic [DATA_W*LANES-1:0]   ReadBus,
    output logic                      WE,
    output logic [ADDR_W-1:0]         WriteAddress,
    output logic [DATA_W*LANES-1:0]   WriteBus,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_W-1:0]         cdf_min,
    output logic [DATA_W-1:0]         cdf_total,
    output logic                      overflow
);
    localparam int BUS_W = DATA_W * LANES;
    localparam int WORDS = NUM_BINS / LANES;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0]  LAST_RD = CNT_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] SUM_OFS = ADDR_W'(WORDS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_DRAIN   = 3'd2,
        S_SUMMARY = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cdf_base_q;
    logic [ADDR_W-1:0]   wr_idx_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [CNT_W-1:0]    rd_cnt_q;
    logic [RD_LAT-1:0]   vpipe_q;
    logic [RD_LAT-1:0]   vpipe_d;
    logic [DATA_W-1:0]   run_q;
    logic [DATA_W-1:0]   run_d;
    logic [DATA_W-1:0]   min_q;
    logic [DATA_W-1:0]   min_d;
    logic                ovf_q;
    logic                ovf_d;
    logic [BUS_W-1:0]    wbus_q;
    logic [BUS_W-1:0]    cdf_word_d;
    logic [BUS_W-1:0]    summary_s;
    logic                we_q;
    logic                busy_q;
    logic                done_q;
    logic                ret_s;

    // Lane-by-lane prefix sums of the returned word on top of the running total.
    always_comb begin
        logic [DATA_W:0] sum_v;
        sum_v      = '0;
        run_d      = run_q;
        min_d      = min_q;
        ovf_d      = ovf_q;
        cdf_word_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_v = {1'b0, run_d} + {1'b0, ReadBus[BUS_W-1-i*DATA_W -: DATA_W]};
            run_d = sum_v[DATA_W-1:0];
            ovf_d = ovf_d | sum_v[DATA_W];
            // A zero minimum means no nonzero CDF value has been seen yet this run.
            if (min_d == '0) begin
                min_d = run_d;
            end else begin
                min_d = min_d;
            end
            cdf_word_d[BUS_W-1-i*DATA_W -: DATA_W] = run_d;
        end
    end

    // Read-valid shift register and summary word assembly.
    always_comb begin
        vpipe_d    = '0;
        vpipe_d[0] = (state_q == S_READ);
        for (int i = 1; i < RD_LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end
        summary_s = '0;
        summary_s[BUS_W-1 -: 2*DATA_W] = {min_q, run_q};
    end

    assign ret_s = vpipe_q[RD_LAT-1];

    // Control FSM together with the registered datapath and bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cdf_base_q <= '0;
            wr_idx_q   <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rd_cnt_q   <= '0;
            vpipe_q    <= '0;
            run_q      <= '0;
            min_q      <= '0;
            ovf_q      <= 1'b0;
            wbus_q     <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            vpipe_q <= vpipe_d;
            we_q    <= ret_s;
            if (ret_s) begin
                wbus_q    <= cdf_word_d;
                wr_addr_q <= cdf_base_q + wr_idx_q;
                wr_idx_q  <= wr_idx_q + ADDR_W'(1);
                run_q     <= run_d;
                min_q     <= min_d;
                ovf_q     <= ovf_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_READ;
                        rd_addr_q  <= hist_base;
                        cdf_base_q <= cdf_base;
                        run_q      <= '0;
                        min_q      <= '0;
                        ovf_q      <= 1'b0;
                        wr_idx_q   <= '0;
                        rd_cnt_q   <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                S_READ: begin
                    rd_addr_q <= rd_addr_q + ADDR_W'(1);
                    rd_cnt_q  <= rd_cnt_q + CNT_W'(1);
                    if (rd_cnt_q == LAST_RD) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Empty pipe means the last returned word is being written this cycle.
                    if (vpipe_q == '0) begin
                        state_q   <= S_SUMMARY;
                        we_q      <= 1'b1;
                        wr_addr_q <= cdf_base_q + SUM_OFS;
                        wbus_q    <= summary_s;
                    end
                end
                S_SUMMARY: begin
                    state_q <= S_DONE;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ReadAddress  = rd_addr_q;
    assign WE           = we_q;
    assign WriteAddress = wr_addr_q;
    assign WriteBus     = wbus_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cdf_min      = min_q;
    assign cdf_total    = run_q;
    assign overflow     = ovf_q;

endmodule
